iic_cfg_arbiter: RTL and testbench
==================================

Name: iic_cfg_arbiter

Overview:
Shares one IIC write engine (start/busy/done/nack byte-transaction master) between two register-configuration requesters: port 0 is the IR sensor config sequencer, port 1 is the camera config sequencer. Each requester issues single register writes (device address, register address, data). The arbiter grants the engine round-robin, retries NACKed transfers, watchdogs hung transfers, and returns a per-requester done or error pulse. It sits between the per-device config sequencers and the shared SCL/SDA engine, in the 50 MHz config clock domain.

Parameters:
ADDR_W, 16, register address width; legal values 8 or 16.
MAX_RETRY, 2, extra attempts after a NACK before an error is reported; legal range 0..7.
TIMEOUT_CYC, 2000000, clk cycles allowed in WAIT before abort (40 ms at 50 MHz); legal range >= 16.

Ports:
clk  in  1  config clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 (IR) request pending; held until req0_ready
req0_dev  in  7  port 0 7-bit device address
req0_addr  in  ADDR_W  port 0 register address
req0_data  in  8  port 0 write data
req0_ready  out  1  one-cycle pulse: request accepted
req0_done  out  1  one-cycle pulse: write ACKed
req0_err  out  1  one-cycle pulse: NACK after retries, or timeout
req1_*  same set of signals as req0_*, for port 1 (camera)
eng_start  out  1  one-cycle launch pulse to the engine
eng_abort  out  1  one-cycle pulse: engine returns to idle and releases the bus
eng_dev / eng_addr / eng_data  out  7 / ADDR_W / 8  latched transaction fields
eng_busy  in  1  engine active
eng_done  in  1  one-cycle pulse: transfer finished
eng_nack  in  1  sampled only together with eng_done
owner  out  1  port currently granted
busy  out  1  high in every state except IDLE
err_cnt  out  8  saturating count of all reqN_err pulses

Behaviour:
- Reset values: all outputs 0. Internal last_grant resets to 1, so port 0 wins the first tie. The retry counter resets to 0. Reset can arrive in any state and returns the block to IDLE immediately. No abort is issued on reset, because the engine shares rst_n.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Arbitration happens only when eng_busy=0 and at least one reqN_valid=1.
  - A single valid requester wins.
  - If both are valid, the winner is the port != last_grant.
  - On the arbitration edge: latch dev/addr/data into the eng_* registers, set owner, clear the retry counter, go to LAUNCH.
- LAUNCH (1 cycle):
  - eng_start=1.
  - reqN_ready=1 for the owner, on the first attempt only.
  - Clear the timeout counter, go to WAIT.
  - Request-to-eng_start latency is exactly 1 cycle after the arbitration edge.
- WAIT: the timeout counter increments each cycle.
  - eng_done=1 and eng_nack=0: go to RESP, outcome OK.
  - eng_done=1, eng_nack=1, retries < MAX_RETRY: increment retries, go to LAUNCH. No ready pulse; eng_* fields are unchanged.
  - eng_done=1, eng_nack=1, retries = MAX_RETRY: go to RESP, outcome ERR.
  - Counter reaches TIMEOUT_CYC-1 with no eng_done: eng_abort=1 for that cycle, go to RESP, outcome ERR. Timeouts are not retried.
  - eng_done and timeout in the same cycle: eng_done wins.
- RESP (1 cycle):
  - Pulse req<owner>_done or req<owner>_err.
  - On ERR, err_cnt increments, saturating at 255.
  - last_grant <= owner, go to IDLE.
- Lossless requests: a request never granted keeps waiting; valid is never dropped. Round-robin bounds the wait to one transaction of the other port.
- Inputs ignored outside their states: eng_done outside WAIT is ignored. reqN_* field changes after ready do not affect the transfer in flight.

Test Plan:
- Single request. Reset; req0 {dev=0x3C, addr=0x3008, data=0x82}, engine ACKs after 100 cycles. Required: req0_ready in the cycle after arbitration; eng_start with eng_dev=0x3C, eng_addr=0x3008, eng_data=0x82; req0_done exactly 1 cycle after eng_done; err_cnt=0.
- Tie and round-robin. req0 and req1 valid in the same cycle, both held for 4 back-to-back writes. Required: grants in order 0,1,0,1; each transfer fully completes before the next eng_start.
- NACK retry, MAX_RETRY=2:
  - Engine NACKs twice, then ACKs: 3 eng_start pulses, one req1_ready, req1_done, no err.
  - Engine NACKs 3 times: req1_err and err_cnt=1.
- Timeout, TIMEOUT_CYC=16. Engine never pulses done. Required: eng_abort and req0_err exactly 16 cycles after entering WAIT; then a pending req1 is granted.
- Busy gating and reset mid-transfer:
  - eng_busy=1 with req0 valid: no grant until eng_busy=0.
  - rst_n low during WAIT: all outputs are 0 at once; after release, still-valid req0 is re-granted from IDLE.
- Done/timeout collision. TIMEOUT_CYC=16 with eng_done (ACK) on the 16th WAIT cycle. Required: req0_done, no eng_abort, err_cnt unchanged.

Source files
------------

// File: rtl/iic_cfg_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// iic_cfg_arbiter
//
// Purpose:
//   Shares one IIC byte-write engine between two register-configuration
//   requesters (port 0 = IR sensor sequencer, port 1 = camera sequencer).
//   Grants are round-robin, NACKed writes are retried up to MAX_RETRY extra
//   times, hung transfers are aborted by a watchdog, and each requester gets
//   a one-cycle done or err pulse per accepted write.
//
// Ports:
//   clk, rst_n                  50 MHz config clock, async active-low reset
//   reqN_valid/dev/addr/data    request from port N, held until reqN_ready
//   reqN_ready                  pulse: request accepted (first attempt only)
//   reqN_done / reqN_err        pulse: write ACKed / failed (NACK or timeout)
//   eng_start / eng_abort       pulses to the shared engine
//   eng_dev/eng_addr/eng_data   latched fields of the transfer in flight
//   eng_busy/eng_done/eng_nack  engine status (nack valid only with done)
//   owner                       port currently granted
//   busy                        high whenever the arbiter is not idle
//   err_cnt                     saturating count of all reqN_err pulses
// ---------------------------------------------------------------------------
module iic_cfg_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [6:0]        req0_dev,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [7:0]        req0_data,
  output logic              req0_ready,
  output logic              req0_done,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic [6:0]        req1_dev,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [7:0]        req1_data,
  output logic              req1_ready,
  output logic              req1_done,
  output logic              req1_err,
  output logic              eng_start,
  output logic              eng_abort,
  output logic [6:0]        eng_dev,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [7:0]        eng_data,
  input  logic              eng_busy,
  input  logic              eng_done,
  input  logic              eng_nack,
  output logic              owner,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int              TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      RETRY_LIM = 3'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_busy;
  logic [2:0]        r_retry;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_resp_err;
  logic [7:0]        r_err_cnt;
  logic              r_eng_start;
  logic              r_eng_abort;
  logic [6:0]        r_eng_dev;
  logic [ADDR_W-1:0] r_eng_addr;
  logic [7:0]        r_eng_data;
  logic [1:0]        r_req_ready;
  logic [1:0]        r_req_done;
  logic [1:0]        r_req_err;

  logic              w_arb_go;
  logic              w_pick;
  logic [6:0]        w_sel_dev;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [7:0]        w_sel_data;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Only arbitrate while the engine is free; on a tie the port that did not
  // go last wins, otherwise the single valid port wins.
  assign w_arb_go   = !eng_busy && (req0_valid || req1_valid);
  assign w_pick     = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_sel_dev  = w_pick ? req1_dev  : req0_dev;
  assign w_sel_addr = w_pick ? req1_addr : req0_addr;
  assign w_sel_data = w_pick ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_busy       <= 1'b0;
      r_retry      <= 3'd0;
      r_to_cnt     <= '0;
      r_resp_err   <= 1'b0;
      r_err_cnt    <= 8'd0;
      r_eng_start  <= 1'b0;
      r_eng_abort  <= 1'b0;
      r_eng_dev    <= 7'd0;
      r_eng_addr   <= '0;
      r_eng_data   <= 8'd0;
      r_req_ready  <= 2'b00;
      r_req_done   <= 2'b00;
      r_req_err    <= 2'b00;
    end else begin
      // All strobes are single-cycle; they are re-armed only on transitions.
      r_eng_start <= 1'b0;
      r_eng_abort <= 1'b0;
      r_req_ready <= 2'b00;
      r_req_done  <= 2'b00;
      r_req_err   <= 2'b00;

      case (r_state)
        S_IDLE: begin
          if (w_arb_go) begin
            r_eng_dev            <= w_sel_dev;
            r_eng_addr           <= w_sel_addr;
            r_eng_data           <= w_sel_data;
            r_owner              <= w_pick;
            r_retry              <= 3'd0;
            r_eng_start          <= 1'b1;
            r_req_ready[w_pick]  <= 1'b1;
            r_busy               <= 1'b1;
            r_state              <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT;
        end

        S_WAIT: begin
          // eng_done is checked first so a completion on the last watchdog
          // cycle is reported as a normal completion, not an abort.
          if (eng_done) begin
            if (!eng_nack) begin
              r_req_done[r_owner] <= 1'b1;
              r_resp_err          <= 1'b0;
              r_state             <= S_RESP;
            end else if (r_retry < RETRY_LIM) begin
              // Relaunch with the same latched fields; no new ready pulse.
              r_retry     <= r_retry + 3'd1;
              r_eng_start <= 1'b1;
              r_state     <= S_LAUNCH;
            end else begin
              r_req_err[r_owner] <= 1'b1;
              r_resp_err         <= 1'b1;
              r_state            <= S_RESP;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_eng_abort        <= 1'b1;
            r_req_err[r_owner] <= 1'b1;
            r_resp_err         <= 1'b1;
            r_state            <= S_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        S_RESP: begin
          if (r_resp_err) begin
            r_err_cnt <= sat_inc8(r_err_cnt);
          end
          r_last_grant <= r_owner;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_ready = r_req_ready[0];
  assign req1_ready = r_req_ready[1];
  assign req0_done  = r_req_done[0];
  assign req1_done  = r_req_done[1];
  assign req0_err   = r_req_err[0];
  assign req1_err   = r_req_err[1];
  assign eng_start  = r_eng_start;
  assign eng_abort  = r_eng_abort;
  assign eng_dev    = r_eng_dev;
  assign eng_addr   = r_eng_addr;
  assign eng_data   = r_eng_data;
  assign owner      = r_owner;
  assign busy       = r_busy;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_iic_cfg_arbiter.sv
`timescale 1ns/1ps
module tb_iic_cfg_arbiter;

  localparam int ADDR_W    = 16;
  localparam int MAX_RETRY = 2;
  localparam int TO        = 16;
  localparam int TO_LONG   = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]              vld;
  logic [1:0][6:0]         dev;
  logic [1:0][ADDR_W-1:0]  addr;
  logic [1:0][7:0]         data;
  logic                    eng_busy, eng_done, eng_nack;

  // Main instance (short watchdog)
  logic [1:0]        rdy, dn, er;
  logic              e_start, e_abort, own, bsy;
  logic [6:0]        e_dev;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]        e_data, ecnt;

  // Long-watchdog instance, used for the 100-cycle single write
  logic [1:0]        l_rdy, l_dn, l_er;
  logic              l_start, l_abort, l_own, l_bsy;
  logic [6:0]        l_dev;
  logic [ADDR_W-1:0] l_addr;
  logic [7:0]        l_data, l_ecnt;

  logic [48:0] main_outs, long_outs;
  assign main_outs = {rdy, dn, er, e_start, e_abort, e_dev, e_addr, e_data, own, bsy, ecnt};
  assign long_outs = {l_rdy, l_dn, l_er, l_start, l_abort, l_dev, l_addr, l_data, l_own, l_bsy, l_ecnt};

  iic_cfg_arbiter #(.ADDR_W(ADDR_W), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(vld[0]), .req0_dev(dev[0]), .req0_addr(addr[0]), .req0_data(data[0]),
    .req0_ready(rdy[0]), .req0_done(dn[0]), .req0_err(er[0]),
    .req1_valid(vld[1]), .req1_dev(dev[1]), .req1_addr(addr[1]), .req1_data(data[1]),
    .req1_ready(rdy[1]), .req1_done(dn[1]), .req1_err(er[1]),
    .eng_start(e_start), .eng_abort(e_abort),
    .eng_dev(e_dev), .eng_addr(e_addr), .eng_data(e_data),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_nack(eng_nack),
    .owner(own), .busy(bsy), .err_cnt(ecnt)
  );

  iic_cfg_arbiter #(.ADDR_W(ADDR_W), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TO_LONG)) u_dut_long (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(vld[0]), .req0_dev(dev[0]), .req0_addr(addr[0]), .req0_data(data[0]),
    .req0_ready(l_rdy[0]), .req0_done(l_dn[0]), .req0_err(l_er[0]),
    .req1_valid(vld[1]), .req1_dev(dev[1]), .req1_addr(addr[1]), .req1_data(data[1]),
    .req1_ready(l_rdy[1]), .req1_done(l_dn[1]), .req1_err(l_er[1]),
    .eng_start(l_start), .eng_abort(l_abort),
    .eng_dev(l_dev), .eng_addr(l_addr), .eng_data(l_data),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_nack(eng_nack),
    .owner(l_own), .busy(l_bsy), .err_cnt(l_ecnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int m_last  = 1;   // reference: port that was granted last
  int m_ec    = 0;   // reference: error count

  typedef struct {
    bit raise0;      // present a new request on port 0 (if not already pending)
    bit raise1;
    int nn;          // engine NACKs this many attempts before ACKing
    int hang;        // attempt index on which the engine never answers (-1: none)
    int dly;         // WAIT cycle on which the engine answers
    int exp_p;       // expected granted port
    int exp_starts;  // expected eng_start pulses
    bit exp_ok;      // expected done (1) or err (0)
    int exp_ec;      // expected err_cnt afterwards
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic raise(input int p);
    if (!vld[p]) begin
      dev[p]  = 7'($urandom);
      addr[p] = ADDR_W'($urandom);
      data[p] = 8'($urandom);
      vld[p]  = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld = '0; eng_busy = 0; eng_done = 0; eng_nack = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last = 1; m_ec = 0;
  endtask

  // Outcome of one accepted write from the engine's behaviour script.
  function automatic void predict(input int nn, input int hang, output int starts, output bit ok);
    bit fin;
    starts = 0; ok = 0; fin = 0;
    for (int a = 0; a <= MAX_RETRY && !fin; a++) begin
      starts++;
      if (a == hang) fin = 1;
      else if (a >= nn) begin ok = 1; fin = 1; end
    end
  endfunction

  // Waits for the grant, plays the engine, and checks the whole transaction.
  task automatic exec_txn(input int exp_p, input int nn, input int hang, input int dly,
                          input int exp_starts, input bit exp_ok, input int exp_ec);
    bit got, fin, hung;
    int starts, k;
    logic [6:0]        xd;
    logic [ADDR_W-1:0] xa;
    logic [7:0]        xdat;
    xd = dev[exp_p]; xa = addr[exp_p]; xdat = data[exp_p];
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      got = e_start;
    end
    check("grant_start", got, 1);
    if (!got) return;
    check("owner", own, exp_p);
    check("ready_owner", rdy[exp_p], 1);
    check("ready_other", rdy[1-exp_p], 0);
    check("eng_fields", {e_dev, e_addr, e_data}, {xd, xa, xdat});
    // Requester drops the request after ready and scribbles on its fields.
    vld[exp_p] = 1'b0; dev[exp_p] = ~xd; addr[exp_p] = ~xa; data[exp_p] = ~xdat;
    eng_busy = 1; starts = 1; fin = 0; hung = 0;
    for (int a = 0; a < 8 && !fin; a++) begin
      if (a == hang) begin
        hung = 1; got = 0; k = 0;
        for (int i = 1; i <= TO + 4 && !got; i++) begin
          @(negedge clk);
          if (e_abort || er[exp_p]) begin got = 1; k = i; end
        end
        check("timeout_latency", k, TO + 1);
        fin = 1;
      end else begin
        repeat (dly) @(negedge clk);
        eng_done = 1; eng_nack = (a < nn);
        @(negedge clk);
        eng_done = 0; eng_nack = 0;
        if (e_start) begin
          starts++;
          check("retry_no_ready", rdy, 0);
          check("retry_fields", {e_dev, e_addr, e_data}, {xd, xa, xdat});
        end else fin = 1;
      end
    end
    check("starts", starts, exp_starts);
    check("done_pulse", dn[exp_p], exp_ok);
    check("err_pulse", er[exp_p], !exp_ok);
    check("other_resp", {dn[1-exp_p], er[1-exp_p]}, 0);
    check("abort", e_abort, hung);
    check("busy_resp", bsy, 1);
    eng_busy = 0;
    @(negedge clk);
    check("err_cnt", ecnt, exp_ec);
    check("busy_idle", bsy, 0);
    m_last = exp_p; m_ec = exp_ec;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, nn, hang, dly, p, st, ec;
    bit ok, got;

    //           r0 r1 nn hang dly  p st ok ec
    tbl[0]  = '{1, 1, 0, -1,  3, 0, 1, 1, 0};  // tie: port 0 first
    tbl[1]  = '{1, 0, 0, -1,  5, 1, 1, 1, 0};  // round-robin
    tbl[2]  = '{0, 1, 0, -1,  2, 0, 1, 1, 0};
    tbl[3]  = '{1, 0, 0, -1,  4, 1, 1, 1, 0};
    tbl[4]  = '{0, 0, 0, -1,  2, 0, 1, 1, 0};  // leftover port 0
    tbl[5]  = '{0, 1, 2, -1,  3, 1, 3, 1, 0};  // two NACKs then ACK
    tbl[6]  = '{0, 1, 3, -1,  3, 1, 3, 0, 1};  // retries exhausted
    tbl[7]  = '{1, 1, 0,  0,  1, 0, 1, 0, 2};  // timeout, port 1 waiting
    tbl[8]  = '{0, 0, 0, -1,  6, 1, 1, 1, 2};  // port 1 granted next
    tbl[9]  = '{1, 0, 1,  1,  2, 0, 2, 0, 3};  // NACK, then hang on retry
    tbl[10] = '{1, 0, 0, -1, 16, 0, 1, 1, 3};  // done on last watchdog cycle

    vld = '0; dev = '0; addr = '0; data = '0;
    eng_busy = 0; eng_done = 0; eng_nack = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", main_outs, 0);
    check("reset_outputs_long", long_outs, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, engine answers after 100 cycles
    dev[0] = 7'h3C; addr[0] = 16'h3008; data[0] = 8'h82; vld[0] = 1'b1;
    @(negedge clk);
    check("single_start", l_start, 1);
    check("single_ready", l_rdy, 2'b01);
    check("single_fields", {l_dev, l_addr, l_data}, {7'h3C, 16'h3008, 8'h82});
    vld[0] = 1'b0; eng_busy = 1;
    repeat (100) @(negedge clk);
    eng_done = 1;
    @(negedge clk);
    eng_done = 0; eng_busy = 0;
    check("single_done", {l_dn, l_er}, 4'b0100);
    @(negedge clk);
    check("single_err_cnt", l_ecnt, 0);
    check("single_idle", l_bsy, 0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].raise0) raise(0);
      if (tbl[i].raise1) raise(1);
      exec_txn(tbl[i].exp_p, tbl[i].nn, tbl[i].hang, tbl[i].dly,
               tbl[i].exp_starts, tbl[i].exp_ok, tbl[i].exp_ec);
    end

    // Stray eng_done while idle must not produce a response
    eng_done = 1;
    @(negedge clk);
    check("stray_done", {dn, er, bsy}, 0);
    eng_done = 0;

    // Engine busy blocks arbitration
    eng_busy = 1; raise(0); k = 0;
    repeat (6) begin
      @(negedge clk);
      if (e_start) k++;
    end
    check("busy_gate_no_start", k, 0);
    check("busy_gate_idle", bsy, 0);
    eng_busy = 0;
    exec_txn(0, 0, -1, 4, 1, 1, m_ec);

    // Reset in the middle of WAIT, request still held
    raise(0); got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      got = e_start;
    end
    check("mid_start", got, 1);
    eng_busy = 1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", main_outs, 0);
    eng_busy = 0;
    @(negedge clk);
    rst_n = 1'b1; m_last = 1; m_ec = 0;
    exec_txn(0, 0, -1, 5, 1, 1, 0);

    // Randomised traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      if (!vld[0] && $urandom_range(0, 1) == 1) raise(0);
      if (!vld[1] && $urandom_range(0, 1) == 1) raise(1);
      if (vld == 2'b00) raise(int'($urandom_range(0, 1)));
      nn   = int'($urandom_range(0, 3));
      hang = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1;
      dly  = int'($urandom_range(1, 16));
      p    = (vld[0] && vld[1]) ? 1 - m_last : (vld[1] ? 1 : 0);
      predict(nn, hang, st, ok);
      ec   = (!ok && m_ec < 255) ? m_ec + 1 : m_ec;
      exec_txn(p, nn, hang, dly, st, ok, ec);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
